// File: rtl/csr_file.sv
// -----------------------------------------------------------------------------
// csr_file
//
// Machine-mode control and status register file for the RV32IMAC core.
// Serves Zicsr RW/RS/RC accesses from the execute stage with a combinational
// read path, records trap entry and mret state, keeps free-running cycle and
// retired-instruction counters, samples the interrupt lines into mip and
// raises a registered interrupt request towards the trap controller.
//
// Ports:
//   clk, rst                 clock and asynchronous active-low reset
//   csr_en, csr_op           access valid / operation (01 RW, 10 RS, 11 RC)
//   csr_addr, csr_wdata      CSR address and rs1/uimm operand
//   csr_wr_suppress          access is read-only (x0 / uimm=0 on RS/RC)
//   csr_rdata, csr_illegal   old CSR value and illegal-access flag (comb.)
//   instret_inc              one instruction retired this cycle
//   trap_valid, trap_pc,
//   trap_cause, trap_tval    trap entry request and its information
//   mret                     mret retires this cycle
//   irq_sw/timer/ext         raw interrupt lines
//   mtvec_o, mepc_o          current mtvec / mepc values
//   irq_pending              registered interrupt request
// -----------------------------------------------------------------------------
module csr_file #(
    parameter logic [31:0] HART_ID     = 32'h0000_0000,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int          CNT_WIDTH   = 64,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_1105
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_en,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic        csr_wr_suppress,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        instret_inc,
    input  logic        trap_valid,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_tval,
    input  logic        mret,
    input  logic        irq_sw,
    input  logic        irq_timer,
    input  logic        irq_ext,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic        irq_pending
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    // Per-register write masks; only these bits ever hold state.
    localparam logic [31:0] MSTATUS_MASK = 32'h0000_0088;
    localparam logic [31:0] MIE_MASK     = 32'h0000_0888;
    localparam logic [31:0] MTVEC_MASK   = 32'hFFFF_FFFC;
    localparam logic [31:0] MEPC_MASK    = 32'hFFFF_FFFE;
    // MPP is hard-wired to machine mode and is merged in on read.
    localparam logic [31:0] MSTATUS_MPP  = 32'h0000_1800;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;

    logic [31:0]          mstatus_q;
    logic [31:0]          mie_q;
    logic [31:0]          mtvec_q;
    logic [31:0]          mscratch_q;
    logic [31:0]          mepc_q;
    logic [31:0]          mcause_q;
    logic [31:0]          mtval_q;
    logic [31:0]          mip_q;
    logic [CNT_WIDTH-1:0] cycle_q;
    logic [CNT_WIDTH-1:0] instret_q;

    logic [63:0] cycle_ext;
    logic [63:0] instret_ext;
    logic [63:0] cycle_next;
    logic [63:0] instret_next;
    logic [31:0] read_val;
    logic        addr_hit;
    logic [31:0] write_val;
    logic        wr_en;

    // Counters are viewed as 64 bits; bits at and above CNT_WIDTH read as 0.
    assign cycle_ext   = 64'(cycle_q);
    assign instret_ext = 64'(instret_q);

    // Address decode and read mux. Unimplemented addresses clear addr_hit.
    always_comb begin
        read_val = 32'h0;
        addr_hit = 1'b1;
        case (csr_addr)
            ADDR_MSTATUS:   read_val = mstatus_q | MSTATUS_MPP;
            ADDR_MISA:      read_val = MISA_VALUE;
            ADDR_MIE:       read_val = mie_q;
            ADDR_MTVEC:     read_val = mtvec_q;
            ADDR_MSCRATCH:  read_val = mscratch_q;
            ADDR_MEPC:      read_val = mepc_q;
            ADDR_MCAUSE:    read_val = mcause_q;
            ADDR_MTVAL:     read_val = mtval_q;
            ADDR_MIP:       read_val = mip_q;
            ADDR_MCYCLE,
            ADDR_CYCLE:     read_val = cycle_ext[31:0];
            ADDR_MCYCLEH,
            ADDR_CYCLEH:    read_val = cycle_ext[63:32];
            ADDR_MINSTRET,
            ADDR_INSTRET:   read_val = instret_ext[31:0];
            ADDR_MINSTRETH,
            ADDR_INSTRETH:  read_val = instret_ext[63:32];
            ADDR_MHARTID:   read_val = HART_ID;
            default:        addr_hit = 1'b0;
        endcase
    end

    // Address space 11xx is read-only, so only a suppressed access is legal.
    assign csr_illegal = csr_en & (~addr_hit
                                   | (csr_op == 2'b00)
                                   | ((csr_addr[11:10] == 2'b11) & ~csr_wr_suppress));

    assign csr_rdata = csr_illegal ? 32'h0 : read_val;

    // Unmasked new value; the per-register mask is applied at the write.
    always_comb begin
        write_val = csr_wdata;
        case (csr_op)
            2'b10:   write_val = read_val | csr_wdata;
            2'b11:   write_val = read_val & ~csr_wdata;
            default: write_val = csr_wdata;
        endcase
    end

    // Traps and mret take the cycle; a CSR write alongside them is dropped.
    assign wr_en = csr_en & ~csr_illegal & ~csr_wr_suppress & ~trap_valid & ~mret;

    // Counter next values: an explicit write to one half replaces that half
    // and holds the other, suppressing the increment for that cycle.
    always_comb begin
        cycle_next   = cycle_ext + 64'd1;
        instret_next = instret_ext + {63'd0, instret_inc};
        if (wr_en && csr_addr == ADDR_MCYCLE) begin
            cycle_next = {cycle_ext[63:32], write_val};
        end else if (wr_en && csr_addr == ADDR_MCYCLEH) begin
            cycle_next = {write_val, cycle_ext[31:0]};
        end
        if (wr_en && csr_addr == ADDR_MINSTRET) begin
            instret_next = {instret_ext[63:32], write_val};
        end else if (wr_en && csr_addr == ADDR_MINSTRETH) begin
            instret_next = {write_val, instret_ext[31:0]};
        end
    end

    // State update. irq_pending uses the pre-update mstatus/mip/mie so an
    // irq edge takes one cycle into mip and a second into irq_pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mstatus_q   <= 32'h0;
            mie_q       <= 32'h0;
            mtvec_q     <= MTVEC_RESET & MTVEC_MASK;
            mscratch_q  <= 32'h0;
            mepc_q      <= 32'h0;
            mcause_q    <= 32'h0;
            mtval_q     <= 32'h0;
            mip_q       <= 32'h0;
            cycle_q     <= '0;
            instret_q   <= '0;
            irq_pending <= 1'b0;
        end else begin
            mip_q       <= {20'h0, irq_ext, 3'b000, irq_timer, 3'b000, irq_sw, 3'b000};
            irq_pending <= mstatus_q[MIE_BIT] & |(mip_q & mie_q);
            cycle_q     <= cycle_next[CNT_WIDTH-1:0];
            instret_q   <= instret_next[CNT_WIDTH-1:0];
            if (trap_valid) begin
                mepc_q    <= trap_pc & MEPC_MASK;
                mcause_q  <= trap_cause;
                mtval_q   <= trap_tval;
                mstatus_q <= {24'h0, mstatus_q[MIE_BIT], 7'h0};
            end else if (mret) begin
                mstatus_q <= {24'h0, 1'b1, 3'b000, mstatus_q[MPIE_BIT], 3'b000};
            end else if (wr_en) begin
                case (csr_addr)
                    ADDR_MSTATUS:  mstatus_q  <= write_val & MSTATUS_MASK;
                    ADDR_MIE:      mie_q      <= write_val & MIE_MASK;
                    ADDR_MTVEC:    mtvec_q    <= write_val & MTVEC_MASK;
                    ADDR_MSCRATCH: mscratch_q <= write_val;
                    ADDR_MEPC:     mepc_q     <= write_val & MEPC_MASK;
                    ADDR_MCAUSE:   mcause_q   <= write_val;
                    ADDR_MTVAL:    mtval_q    <= write_val;
                    default:       ;
                endcase
            end
        end
    end

    assign mtvec_o = mtvec_q;
    assign mepc_o  = mepc_q;

endmodule

// File: tb/tb_csr_file.sv
// -----------------------------------------------------------------------------
// tb_csr_file
//
// Self-checking bench for csr_file: directed scenarios followed by a random
// run, all compared against a behavioural model built from address tables,
// write masks and plain 64-bit counters.
// -----------------------------------------------------------------------------
module tb_csr_file;

    localparam logic [31:0] HART_ID     = 32'h0000_0003;
    localparam logic [31:0] MTVEC_RESET = 32'h0000_0101;

    logic        clk;
    logic        rst;
    logic        csr_en;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_wr_suppress;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        instret_inc;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic [31:0] trap_tval;
    logic        mret;
    logic        irq_sw;
    logic        irq_timer;
    logic        irq_ext;
    logic [31:0] mtvec_o;
    logic [31:0] mepc_o;
    logic        irq_pending;

    int n_checks = 0;
    int n_fail   = 0;

    csr_file #(
        .HART_ID    (HART_ID),
        .MTVEC_RESET(MTVEC_RESET),
        .CNT_WIDTH  (64),
        .MISA_VALUE (32'h4000_1105)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .csr_en         (csr_en),
        .csr_op         (csr_op),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .csr_wr_suppress(csr_wr_suppress),
        .csr_rdata      (csr_rdata),
        .csr_illegal    (csr_illegal),
        .instret_inc    (instret_inc),
        .trap_valid     (trap_valid),
        .trap_pc        (trap_pc),
        .trap_cause     (trap_cause),
        .trap_tval      (trap_tval),
        .mret           (mret),
        .irq_sw         (irq_sw),
        .irq_timer      (irq_timer),
        .irq_ext        (irq_ext),
        .mtvec_o        (mtvec_o),
        .mepc_o         (mepc_o),
        .irq_pending    (irq_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: plain register images and 64-bit counters.
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mip;
    logic [63:0] m_cycle, m_instret;
    logic        m_pending;

    task automatic m_reset();
        m_mstatus  = 32'h0;
        m_mie      = 32'h0;
        m_mtvec    = {MTVEC_RESET[31:2], 2'b00};
        m_mscratch = 32'h0;
        m_mepc     = 32'h0;
        m_mcause   = 32'h0;
        m_mtval    = 32'h0;
        m_mip      = 32'h0;
        m_cycle    = 64'h0;
        m_instret  = 64'h0;
        m_pending  = 1'b0;
    endtask

    function automatic logic m_impl(input logic [11:0] a);
        case (a)
            12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
            12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00,
            12'hC80, 12'hC02, 12'hC82, 12'hF14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus | 32'h1800;
            12'h301: return 32'h4000_1105;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return m_mip;
            12'hB00, 12'hC00: return m_cycle[31:0];
            12'hB80, 12'hC80: return m_cycle[63:32];
            12'hB02, 12'hC02: return m_instret[31:0];
            12'hB82, 12'hC82: return m_instret[63:32];
            12'hF14: return HART_ID;
            default: return 32'h0;
        endcase
    endfunction

    // Bits that a write may change; zero for read-only registers.
    function automatic logic [31:0] m_mask(input logic [11:0] a);
        case (a)
            12'h300: return 32'h0000_0088;
            12'h304: return 32'h0000_0888;
            12'h305: return 32'hFFFF_FFFC;
            12'h341: return 32'hFFFF_FFFE;
            12'h340, 12'h342, 12'h343,
            12'hB00, 12'hB80, 12'hB02, 12'hB82: return 32'hFFFF_FFFF;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_illegal();
        return csr_en && (!m_impl(csr_addr) || csr_op == 2'b00 ||
                          (csr_addr[11:10] == 2'b11 && !csr_wr_suppress));
    endfunction

    // Advances the model by one rising edge using the inputs as driven.
    task automatic m_step();
        logic [31:0] old_v, new_v, masked;
        logic [63:0] next_cycle, next_instret;
        logic        do_wr, next_pend;
        if (!rst) begin
            m_reset();
            return;
        end
        old_v = m_read(csr_addr);
        if (csr_op == 2'b01)      new_v = csr_wdata;
        else if (csr_op == 2'b10) new_v = old_v | csr_wdata;
        else                      new_v = old_v & ~csr_wdata;
        masked = (new_v & m_mask(csr_addr)) | (old_v & ~m_mask(csr_addr));
        do_wr  = csr_en && !m_illegal() && !csr_wr_suppress && !trap_valid && !mret;
        next_pend    = m_mstatus[3] && ((m_mip & m_mie) != 32'h0);
        next_cycle   = m_cycle + 64'd1;
        next_instret = m_instret + (instret_inc ? 64'd1 : 64'd0);
        if (trap_valid) begin
            m_mepc    = {trap_pc[31:1], 1'b0};
            m_mcause  = trap_cause;
            m_mtval   = trap_tval;
            m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
        end else if (mret) begin
            m_mstatus = m_mstatus[7] ? 32'h88 : 32'h80;
        end else if (do_wr) begin
            case (csr_addr)
                12'h300: m_mstatus  = masked & 32'h88;
                12'h304: m_mie      = masked;
                12'h305: m_mtvec    = masked;
                12'h340: m_mscratch = masked;
                12'h341: m_mepc     = masked;
                12'h342: m_mcause   = masked;
                12'h343: m_mtval    = masked;
                12'hB00: next_cycle   = {m_cycle[63:32], masked};
                12'hB80: next_cycle   = {masked, m_cycle[31:0]};
                12'hB02: next_instret = {m_instret[63:32], masked};
                12'hB82: next_instret = {masked, m_instret[31:0]};
                default: ;
            endcase
        end
        m_cycle   = next_cycle;
        m_instret = next_instret;
        m_mip     = (irq_sw ? 32'h8 : 32'h0) | (irq_timer ? 32'h80 : 32'h0) |
                    (irq_ext ? 32'h800 : 32'h0);
        m_pending = next_pend;
    endtask

    // One clock: the model steps on the same edge as the DUT; inputs are
    // changed only afterwards, 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [11:0] a,
                         input logic [31:0] d, input logic sup);
        csr_en          = 1'b1;
        csr_op          = op;
        csr_addr        = a;
        csr_wdata       = d;
        csr_wr_suppress = sup;
    endtask

    task automatic idle();
        csr_en          = 1'b0;
        csr_op          = 2'b00;
        csr_addr        = 12'h000;
        csr_wdata       = 32'h0;
        csr_wr_suppress = 1'b0;
        trap_valid      = 1'b0;
        mret            = 1'b0;
        instret_inc     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        irq_sw = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0;
        trap_pc = 32'h0; trap_cause = 32'h0; trap_tval = 32'h0;
        m_reset();
        tick(); tick();
        rst = 1'b1;
        drive(2'b10, 12'h301, 32'h0, 1'b1);
        #1;
        n_checks++;
        if (csr_rdata !== 32'h4000_1105) begin
            n_fail++; $display("[TB] FAIL misa_read: got %h expected %h", csr_rdata, 32'h4000_1105);
        end
        csr_addr = 12'hF14;
        #1;
        n_checks++;
        if (csr_rdata !== HART_ID) begin
            n_fail++; $display("[TB] FAIL mhartid_read: got %h expected %h", csr_rdata, HART_ID);
        end
        csr_addr = 12'h300;
        #1;
        n_checks++;
        if (csr_rdata !== 32'h0000_1800) begin
            n_fail++; $display("[TB] FAIL mstatus_reset: got %h expected %h", csr_rdata, 32'h0000_1800);
        end
        n_checks++;
        if (mtvec_o !== 32'h0000_0100 || mepc_o !== 32'h0 || irq_pending !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got mtvec %h mepc %h pend %b expected 00000100 00000000 0",
                     mtvec_o, mepc_o, irq_pending);
        end
        tick();
    endtask

    task automatic test_mie_rw_rc();
        drive(2'b01, 12'h304, 32'hFFFF_FFFF, 1'b0);
        tick();
        drive(2'b10, 12'h304, 32'h0, 1'b1);
        #1;
        n_checks++;
        if (csr_rdata !== 32'h888) begin
            n_fail++; $display("[TB] FAIL mie_rw: got %h expected %h", csr_rdata, 32'h888);
        end
        drive(2'b11, 12'h304, 32'h8, 1'b0);
        tick();
        drive(2'b10, 12'h304, 32'h0, 1'b1);
        #1;
        n_checks++;
        if (csr_rdata !== 32'h880) begin
            n_fail++; $display("[TB] FAIL mie_rc: got %h expected %h", csr_rdata, 32'h880);
        end
        tick();
    endtask

    task automatic test_counter_access();
        logic [31:0] expect_v;
        drive(2'b10, 12'hC00, 32'h5, 1'b1);
        #1;
        expect_v = m_cycle[31:0];
        n_checks++;
        if (csr_illegal !== 1'b0 || csr_rdata !== expect_v) begin
            n_fail++;
            $display("[TB] FAIL cycle_ro_read: got ill %b data %h expected ill 0 data %h",
                     csr_illegal, csr_rdata, expect_v);
        end
        tick();
        drive(2'b10, 12'hC00, 32'h5, 1'b0);
        #1;
        n_checks++;
        if (csr_illegal !== 1'b1 || csr_rdata !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL cycle_ro_write: got ill %b data %h expected ill 1 data 0",
                     csr_illegal, csr_rdata);
        end
        tick();
        drive(2'b10, 12'hC00, 32'h0, 1'b1);
        #1;
        expect_v = m_cycle[31:0];
        n_checks++;
        if (csr_rdata !== expect_v) begin
            n_fail++; $display("[TB] FAIL cycle_after_illegal: got %h expected %h", csr_rdata, expect_v);
        end
        drive(2'b01, 12'h7C0, 32'h1, 1'b0);
        #1;
        n_checks++;
        if (csr_illegal !== 1'b1 || csr_rdata !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL unimpl_addr: got ill %b data %h expected ill 1 data 0",
                     csr_illegal, csr_rdata);
        end
        drive(2'b00, 12'h340, 32'h1, 1'b0);
        #1;
        n_checks++;
        if (csr_illegal !== 1'b1) begin
            n_fail++; $display("[TB] FAIL op00_illegal: got %b expected 1", csr_illegal);
        end
        tick();
        idle();
        tick();
    endtask

    task automatic test_trap_mret();
        drive(2'b01, 12'h300, 32'h8, 1'b0);
        tick();
        drive(2'b01, 12'h340, 32'h1111_1111, 1'b0);
        tick();
        drive(2'b01, 12'h340, 32'hDEAD_BEEF, 1'b0);
        trap_valid = 1'b1;
        trap_pc    = 32'h0000_1235;
        trap_cause = 32'h8000_000B;
        trap_tval  = 32'h0000_CAFE;
        tick();
        trap_valid = 1'b0;
        drive(2'b10, 12'h300, 32'h0, 1'b1);
        #1;
        n_checks++;
        if (mepc_o !== 32'h0000_1234) begin
            n_fail++; $display("[TB] FAIL trap_mepc: got %h expected %h", mepc_o, 32'h0000_1234);
        end
        n_checks++;
        if (csr_rdata !== 32'h0000_1880) begin
            n_fail++; $display("[TB] FAIL trap_mstatus: got %h expected %h", csr_rdata, 32'h0000_1880);
        end
        csr_addr = 12'h340;
        #1;
        n_checks++;
        if (csr_rdata !== 32'h1111_1111) begin
            n_fail++; $display("[TB] FAIL trap_drops_write: got %h expected %h", csr_rdata, 32'h1111_1111);
        end
        csr_addr = 12'h342;
        #1;
        n_checks++;
        if (csr_rdata !== 32'h8000_000B) begin
            n_fail++; $display("[TB] FAIL trap_mcause: got %h expected %h", csr_rdata, 32'h8000_000B);
        end
        idle();
        mret = 1'b1;
        tick();
        mret = 1'b0;
        drive(2'b10, 12'h300, 32'h0, 1'b1);
        #1;
        n_checks++;
        if (csr_rdata !== 32'h0000_1888) begin
            n_fail++; $display("[TB] FAIL mret_mstatus: got %h expected %h", csr_rdata, 32'h0000_1888);
        end
        tick();
    endtask

    task automatic test_counter_wrap();
        idle();
        drive(2'b01, 12'hB00, 32'hFFFF_FFFF, 1'b0);
        tick();
        drive(2'b01, 12'hB80, 32'hFFFF_FFFF, 1'b0);
        tick();
        drive(2'b10, 12'hB00, 32'h0, 1'b1);
        #1;
        n_checks++;
        if (csr_rdata !== 32'hFFFF_FFFF) begin
            n_fail++; $display("[TB] FAIL mcycle_hold: got %h expected %h", csr_rdata, 32'hFFFF_FFFF);
        end
        csr_addr = 12'hB80;
        #1;
        n_checks++;
        if (csr_rdata !== 32'hFFFF_FFFF) begin
            n_fail++; $display("[TB] FAIL mcycleh_write: got %h expected %h", csr_rdata, 32'hFFFF_FFFF);
        end
        tick();
        csr_addr = 12'hB00;
        #1;
        n_checks++;
        if (csr_rdata !== 32'h0) begin
            n_fail++; $display("[TB] FAIL mcycle_wrap_lo: got %h expected 00000000", csr_rdata);
        end
        csr_addr = 12'hC80;
        #1;
        n_checks++;
        if (csr_rdata !== 32'h0) begin
            n_fail++; $display("[TB] FAIL mcycle_wrap_hi: got %h expected 00000000", csr_rdata);
        end
        drive(2'b01, 12'hB02, 32'h0, 1'b0);
        tick();
        drive(2'b01, 12'hB82, 32'h0, 1'b0);
        tick();
        idle();
        instret_inc = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        instret_inc = 1'b0;
        drive(2'b10, 12'hB02, 32'h0, 1'b1);
        #1;
        n_checks++;
        if (csr_rdata !== 32'd3) begin
            n_fail++; $display("[TB] FAIL minstret_count: got %h expected %h", csr_rdata, 32'd3);
        end
        tick();
    endtask

    task automatic test_irq_pending();
        drive(2'b01, 12'h304, 32'h80, 1'b0);
        tick();
        drive(2'b01, 12'h300, 32'h8, 1'b0);
        tick();
        idle();
        irq_sw = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0;
        tick(); tick();
        irq_timer = 1'b1;
        tick();
        irq_timer = 1'b0;
        n_checks++;
        if (irq_pending !== 1'b0) begin
            n_fail++; $display("[TB] FAIL irq_lag1: got %b expected 0", irq_pending);
        end
        tick();
        n_checks++;
        if (irq_pending !== 1'b1) begin
            n_fail++; $display("[TB] FAIL irq_lag2: got %b expected 1", irq_pending);
        end
        tick();
        n_checks++;
        if (irq_pending !== 1'b0) begin
            n_fail++; $display("[TB] FAIL irq_clear: got %b expected 0", irq_pending);
        end
    endtask

    task automatic test_reset_mid_write();
        drive(2'b01, 12'h340, 32'h5555_AAAA, 1'b0);
        #1;
        rst = 1'b0;
        m_reset();
        #1;
        n_checks++;
        if (csr_rdata !== 32'h0 || mtvec_o !== 32'h0000_0100 || mepc_o !== 32'h0 || irq_pending !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got scratch %h mtvec %h mepc %h pend %b expected 0 00000100 0 0",
                     csr_rdata, mtvec_o, mepc_o, irq_pending);
        end
        tick();
        rst = 1'b1;
        drive(2'b10, 12'h340, 32'h0, 1'b1);
        #1;
        n_checks++;
        if (csr_rdata !== 32'h0) begin
            n_fail++; $display("[TB] FAIL reset_aborts_write: got %h expected 00000000", csr_rdata);
        end
        tick();
    endtask

    task automatic test_random();
        logic [11:0] addr_tab [21];
        logic [31:0] exp_rd;
        logic        exp_ill;
        addr_tab = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                     12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00,
                     12'hC80, 12'hC02, 12'hC82, 12'hF14, 12'h7C0, 12'h345, 12'hFFF};
        for (int i = 0; i < 400; i++) begin
            csr_en          = ($urandom_range(0, 7) != 0);
            csr_op          = 2'($urandom_range(0, 3));
            csr_addr        = addr_tab[$urandom_range(0, 20)];
            csr_wdata       = $urandom;
            csr_wr_suppress = ($urandom_range(0, 3) == 0);
            trap_valid      = ($urandom_range(0, 9) == 0);
            mret            = ($urandom_range(0, 9) == 0);
            trap_pc         = $urandom;
            trap_cause      = $urandom;
            trap_tval       = $urandom;
            instret_inc     = 1'($urandom_range(0, 1));
            irq_sw          = ($urandom_range(0, 3) == 0);
            irq_timer       = ($urandom_range(0, 3) == 0);
            irq_ext         = ($urandom_range(0, 3) == 0);
            #1;
            exp_ill = m_illegal();
            exp_rd  = exp_ill ? 32'h0 : m_read(csr_addr);
            n_checks++;
            if (csr_illegal !== exp_ill) begin
                n_fail++;
                $display("[TB] FAIL rand_illegal[%0d] addr %h: got %b expected %b", i, csr_addr, csr_illegal, exp_ill);
            end
            if (csr_en) begin
                n_checks++;
                if (csr_rdata !== exp_rd) begin
                    n_fail++;
                    $display("[TB] FAIL rand_rdata[%0d] addr %h: got %h expected %h", i, csr_addr, csr_rdata, exp_rd);
                end
            end
            n_checks++;
            if (mtvec_o !== m_mtvec || mepc_o !== m_mepc || irq_pending !== m_pending) begin
                n_fail++;
                $display("[TB] FAIL rand_state[%0d]: got mtvec %h mepc %h pend %b expected %h %h %b",
                         i, mtvec_o, mepc_o, irq_pending, m_mtvec, m_mepc, m_pending);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_mie_rw_rc();
        test_counter_access();
        test_trap_mret();
        test_counter_wrap();
        test_irq_pending();
        test_reset_mid_write();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_file.md
# csr_file

Machine-mode control and status register file for the RV32IMAC core. It serves Zicsr read/modify/write accesses from the execute stage, records trap entry and `mret` state, and keeps free-running cycle and retired-instruction counters. It also registers interrupt lines and flags pending interrupts to the trap controller. It sits beside the integer register file; reads are combinational and all state updates occur on the clock edge.

## Interface
- `HART_ID`, 0: value returned by `mhartid`.
- `MTVEC_RESET`, 32'h0000_0000: reset value of `mtvec`.
- `CNT_WIDTH`, 64: counter width, legal range 33..64; bits at and above `CNT_WIDTH` read 0 and are not stored.
- `MISA_VALUE`, 32'h4000_1105: read-only `misa` (MXL=1, extensions I, M, A, C).

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `csr_en` in 1: valid CSR instruction this cycle.
- `csr_op` in 2: 01 = RW, 10 = RS, 11 = RC; 00 is treated as illegal when `csr_en`=1.
- `csr_addr` in 12: CSR address.
- `csr_wdata` in 32: rs1 value or zero-extended uimm.
- `csr_wr_suppress` in 1: source is x0 or uimm=0 on RS/RC; the write is suppressed and the access is read-only.
- `csr_rdata` out 32: old CSR value, combinational.
- `csr_illegal` out 1: combinational illegal-access flag.
- `instret_inc` in 1: one instruction retired this cycle.
- `trap_valid` in 1: take a trap this cycle.
- `trap_pc` in 32, `trap_cause` in 32, `trap_tval` in 32: trap information.
- `mret` in 1: `mret` retires this cycle.
- `irq_sw`, `irq_timer`, `irq_ext` in 1 each: interrupt lines.
- `mtvec_o` out 32, `mepc_o` out 32: current register values.
- `irq_pending` out 1: registered interrupt request.

## Operation
Implemented CSRs (the "writable bits" listed are the only bits that can be written):
- `mstatus` 0x300: writable bits are MIE[3] and MPIE[7]; MPP[12:11] reads 2'b11; all other bits read 0.
- `misa` 0x301: write-ignored (WARL).
- `mie` 0x304: writable bits are MSIE[3], MTIE[7], MEIE[11].
- `mtvec` 0x305: bits [1:0] read 0 (direct mode).
- `mscratch` 0x340: full 32 bits writable.
- `mepc` 0x341: bit 0 reads 0.
- `mcause` 0x342, `mtval` 0x343: full 32 bits writable.
- `mip` 0x344: read-only; bits 3/7/11 hold the registered `irq_sw`/`irq_timer`/`irq_ext`.
- `mcycle` 0xB00, `mcycleh` 0xB80, `minstret` 0xB02, `minstreth` 0xB82: writable.
- `cycle`/`cycleh`/`instret`/`instreth` 0xC00/0xC80/0xC02/0xC82: read-only shadows of the machine counters.
- `mhartid` 0xF14: read-only.

Write value:
- RW: new = `csr_wdata`.
- RS: new = old | `csr_wdata`.
- RC: new = old & ~`csr_wdata`.
- After computing the new value, apply the per-register write mask.

`csr_illegal`=1 when `csr_en`=1 and any of the following holds:
- the address is unimplemented;
- `csr_op`=00;
- `csr_addr[11:10]`=2'b11 and the write is not suppressed.

An illegal access changes no state, and `csr_rdata` reads 0.

Update priority within one cycle, highest first:
- `trap_valid`: `mepc` <= `trap_pc` & ~1; `mcause` <= `trap_cause`; `mtval` <= `trap_tval`; MPIE <= MIE; MIE <= 0. Any CSR write in the same cycle is dropped.
- `mret`: MIE <= MPIE; MPIE <= 1. Any CSR write is dropped.
- Legal, non-suppressed CSR write.

Counters:
- `mcycle` increments every cycle.
- `minstret` increments when `instret_inc`=1.
- Both wrap from all-ones to 0.
- An explicit write to either half of a counter replaces that half; that counter does not increment in that cycle.
- Counters update even in cycles with `trap_valid` or `mret`.

Interrupts:
- `mip` bits are sampled from the irq lines every cycle.
- `irq_pending` <= MIE & |(`mip` & `mie`), computed from the current (pre-update) register values.

## Timing
- Reads have zero latency: `csr_rdata` reflects state before the edge.
- A write is visible to a read in the cycle after the write.
- `irq_pending` lags an irq line edge by 2 cycles (sample into `mip`, then evaluate).
- On reset, all outputs and registers are 0, except:
  - `mtvec` = `MTVEC_RESET`;
  - MPP reads 2'b11.
- Because reset is asynchronous, a reset asserted mid-access aborts that write immediately.

## Test plan
- Reset, then read 0x301, 0xF14 and 0x300 -> reads 32'h4000_1105, `HART_ID` and 32'h0000_1800.
- Write 32'hFFFF_FFFF to `mie` with RW, then RC with 32'h8 -> `mie` reads 32'h888, then 32'h880.
- RS on 0xC00 with `csr_wr_suppress`=1 -> legal, no change; the same access with suppress=0 -> `csr_illegal`=1; address 0x7C0 -> illegal, `csr_rdata`=0.
- Set MIE=1, then assert `trap_valid` with pc 32'h1235, cause 32'h8000_000B and a simultaneous write to `mscratch` -> `mepc`=32'h1234, MIE=0, MPIE=1, `mscratch` unchanged. Then `mret` -> MIE=1, MPIE=1.
- Write `mcycle` to 32'hFFFF_FFFF and `mcycleh` to 32'hFFFF_FFFF, then idle -> `mcycle` holds on the write cycle, then wraps to 0 with carry; assert `instret_inc` for 3 cycles -> `minstret` = 3.
- MIE=1, MTIE=1, pulse `irq_timer` -> `irq_pending` rises exactly 2 cycles later; assert `rst` low mid-write -> all state at reset values with no clock edge needed.
